// File: rtl/busca_controle.sv
// busca_controle: fetch stage and cycle sequencer of the multicycle RISC-V datapath.
// Holds PC, word-addressed instruction memory and the instruction register.
module busca_controle #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic [2:0]        tipo,
    input  logic              desvio,
    input  logic [12:0]       desvio_offset,
    output logic [31:0]       instrucao,
    output logic [31:0]       pc,
    output logic [2:0]        estado,
    output logic              parada
);
    typedef enum logic [2:0] {
        BUSCA      = 3'b000,
        DECODIFICA = 3'b001,
        EXECUTA    = 3'b010,
        MEMORIA    = 3'b011,
        ESCRITA    = 3'b100,
        PARADA     = 3'b111
    } estado_t;

    estado_t     st;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] palavra, pc_seq, alvo;
    logic        fora;

    assign estado  = st;
    assign palavra = mem[pc[ADDR_W+1:2]];
    assign fora    = |pc[31:ADDR_W+2];
    assign pc_seq  = pc + 32'd4;
    assign alvo    = pc + {{19{desvio_offset[12]}}, desvio_offset};

    // memory is never cleared; a same-edge fetch sees the old word
    always_ff @(posedge clk)
        if (prog_we) mem[prog_addr] <= prog_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= BUSCA;
            pc        <= '0;
            instrucao <= '0;
            parada    <= 1'b0;
        end else begin
            case (st)
                BUSCA:
                    if (fora || palavra == '0) begin
                        st     <= PARADA;
                        parada <= 1'b1;
                    end else begin
                        instrucao <= palavra;
                        st        <= DECODIFICA;
                    end
                DECODIFICA: st <= EXECUTA;
                EXECUTA:
                    case (tipo)
                        3'b011:         st <= ESCRITA;
                        3'b000, 3'b010: st <= MEMORIA;
                        3'b110: begin
                            st <= BUSCA;
                            pc <= desvio ? alvo : pc_seq;
                        end
                        default: begin
                            st     <= PARADA;
                            parada <= 1'b1;
                        end
                    endcase
                MEMORIA:
                    if (tipo == 3'b000) st <= ESCRITA;
                    else begin
                        st <= BUSCA;
                        pc <= pc_seq;
                    end
                ESCRITA: begin
                    st <= BUSCA;
                    pc <= pc_seq;
                end
                default: begin
                    st     <= PARADA;
                    parada <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_busca_controle.sv
// tb_busca_controle: randomized and directed checks of busca_controle against
// an instruction-level model (per-format state paths and PC rules).
module tb_busca_controle;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 0, reset = 1, prog_we = 0, desvio = 0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [2:0]    tipo = '0;
    logic [12:0]   desvio_offset = '0;
    logic [31:0]   instrucao, pc;
    logic [2:0]    estado;
    logic          parada;

    int errors = 0, checks = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pc_m = 0, instr_m = 0;

    busca_controle #(.MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .tipo(tipo), .desvio(desvio),
        .desvio_offset(desvio_offset), .instrucao(instrucao), .pc(pc),
        .estado(estado), .parada(parada)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1; prog_addr = a[AW-1:0]; prog_data = d;
        step();
        prog_we = 0;
        mem_m[a] = d;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        pc_m = 0; instr_m = 0;
    endtask

    // One instruction from estado 000; state path comes from the format latency table.
    task automatic run_instr(input logic [2:0] t, input logic d, input logic [12:0] off, output logic halted);
        logic [31:0] w, pc_exp;
        logic [2:0]  seq [$];
        logic        ilegal;
        w = mem_m[pc_m[AW+1:2]];
        halted = 0;
        tipo = t; desvio = d; desvio_offset = off;
        step();
        checks++;
        if (pc_m >= 32'(4 * DEPTH) || w == 0) begin
            if (estado !== 3'b111 || parada !== 1'b1 || instrucao !== instr_m || pc !== pc_m) begin
                errors++;
                $display("FAIL halt_fetch pc=%h: got estado=%b parada=%b instrucao=%h pc=%h, required 111 1 %h %h",
                         pc_m, estado, parada, instrucao, pc, instr_m, pc_m);
            end
            halted = 1;
            return;
        end
        instr_m = w;
        if (estado !== 3'b001 || instrucao !== w || parada !== 1'b0) begin
            errors++;
            $display("FAIL fetch pc=%h: got estado=%b instrucao=%h parada=%b, required 001 %h 0", pc_m, estado, instrucao, parada, w);
        end
        ilegal = 0;
        case (t)
            3'b011:  seq = '{3'b010, 3'b100, 3'b000};
            3'b000:  seq = '{3'b010, 3'b011, 3'b100, 3'b000};
            3'b010:  seq = '{3'b010, 3'b011, 3'b000};
            3'b110:  seq = '{3'b010, 3'b000};
            default: begin seq = '{3'b010, 3'b111}; ilegal = 1; end
        endcase
        pc_exp = ilegal ? pc_m : (t == 3'b110 && d) ? pc_m + 32'(int'($signed(off))) : pc_m + 32'd4;
        foreach (seq[i]) begin
            step();
            checks++;
            if (estado !== seq[i] || pc !== (i == seq.size() - 1 ? pc_exp : pc_m)) begin
                errors++;
                $display("FAIL seq tipo=%b cycle=%0d: got estado=%b pc=%h, required %b %h",
                         t, i, estado, pc, seq[i], (i == seq.size() - 1 ? pc_exp : pc_m));
            end
        end
        if (ilegal) begin
            checks++;
            if (parada !== 1'b1) begin errors++; $display("FAIL illegal_parada: got %b, required 1", parada); end
        end
        pc_m = pc_exp;
        halted = ilegal;
    endtask

    task automatic test_reset();
        logic h;
        load(0, 32'h00208133); load(1, 32'h00308233); load(2, 32'h00208133);
        do_reset();
        checks++;
        if (estado !== 3'b000 || pc !== 0 || instrucao !== 0 || parada !== 0) begin
            errors++;
            $display("FAIL reset_state: got estado=%b pc=%h instrucao=%h parada=%b, required 000 0 0 0", estado, pc, instrucao, parada);
        end
        run_instr(3'b011, 0, 0, h);
        run_instr(3'b011, 0, 0, h);
        tipo = 3'b011;
        step(); step();
        checks++;
        if (estado !== 3'b010 || pc !== 32'h8 || instrucao !== 32'h00208133) begin
            errors++;
            $display("FAIL pre_reset: got estado=%b pc=%h instrucao=%h, required 010 8 00208133", estado, pc, instrucao);
        end
        reset = 1;
        #1;
        checks++;
        if (estado !== 3'b000 || pc !== 0 || instrucao !== 0 || parada !== 0) begin
            errors++;
            $display("FAIL async_reset: got estado=%b pc=%h instrucao=%h, required 000 0 0", estado, pc, instrucao);
        end
        #1 reset = 0;
        pc_m = 0; instr_m = 0;
        step();
        checks++;
        if (estado !== 3'b001 || instrucao !== 32'h00208133) begin
            errors++;
            $display("FAIL refetch_after_reset: got estado=%b instrucao=%h, required 001 00208133", estado, instrucao);
        end
        do_reset();
    endtask

    task automatic test_r();
        logic h;
        load(0, 32'h00208133);
        do_reset();
        run_instr(3'b011, 0, 0, h);
    endtask

    task automatic test_s_i();
        logic h;
        load(0, 32'h0020a023); load(1, 32'h0000a103);
        do_reset();
        run_instr(3'b010, 0, 0, h);
        run_instr(3'b000, 0, 0, h);
    endtask

    task automatic test_branch();
        logic h;
        for (int i = 0; i < 4; i++) load(i, 32'h00208133 + i);
        load(4, 32'h00208463); load(5, 32'h00208133);
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 4; i++) run_instr(3'b011, 0, 0, h);
            run_instr(3'b110, k == 0, 13'h1FF8, h);
        end
        run_instr(3'b011, 1, 13'h1FF8, h);
    endtask

    task automatic test_halt();
        logic h;
        load(0, 32'h00208133); load(1, 32'h00308233); load(2, 32'h0);
        do_reset();
        run_instr(3'b011, 0, 0, h);
        run_instr(3'b000, 0, 0, h);
        run_instr(3'b011, 0, 0, h);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL zero_word_halt: got halted=%b, required 1", h); end
        for (int i = 0; i < 10; i++) begin
            desvio = 1; tipo = 3'b110;
            step();
            checks++;
            if (estado !== 3'b111 || pc !== 32'h8 || parada !== 1'b1 || instrucao !== 32'h00308233) begin
                errors++;
                $display("FAIL halt_hold %0d: got estado=%b pc=%h parada=%b instrucao=%h, required 111 8 1 00308233", i, estado, pc, parada, instrucao);
            end
        end
        reset = 1;
        #1;
        checks++;
        if (parada !== 1'b0 || estado !== 3'b000) begin
            errors++;
            $display("FAIL halt_reset: got parada=%b estado=%b, required 0 000", parada, estado);
        end
        step();
        reset = 0; pc_m = 0; instr_m = 0;
    endtask

    task automatic test_range();
        logic h;
        load(0, 32'h00208463);
        do_reset();
        run_instr(3'b110, 1, 13'h0100, h);
        run_instr(3'b011, 0, 0, h);
        checks++;
        if (h !== 1'b1) begin errors++; $display("FAIL range_halt: got halted=%b, required 1", h); end
        do_reset();
    endtask

    task automatic test_collision();
        logic h;
        load(0, 32'h00208133);
        do_reset();
        prog_we = 1; prog_addr = 0; prog_data = 32'h00a50533;
        step();
        prog_we = 0;
        mem_m[0] = 32'h00a50533;
        checks++;
        if (instrucao !== 32'h00208133 || estado !== 3'b001) begin
            errors++;
            $display("FAIL collision_old: got instrucao=%h estado=%b, required 00208133 001", instrucao, estado);
        end
        tipo = 3'b011;
        step(); step(); step();
        checks++;
        if (estado !== 3'b000 || pc !== 32'h4) begin
            errors++;
            $display("FAIL collision_finish: got estado=%b pc=%h, required 000 4", estado, pc);
        end
        do_reset();
        run_instr(3'b011, 0, 0, h);
    endtask

    task automatic test_random();
        logic        h;
        logic [2:0]  t;
        int          o, r;
        for (int i = 0; i < DEPTH; i++) load(i, ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1));
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            t = r < 2 ? 3'b011 : r < 4 ? 3'b000 : r < 6 ? 3'b010 : r < 9 ? 3'b110 : 3'b101;
            o = (int'($urandom_range(0, 32)) - 16) * 4;
            run_instr(t, 1'($urandom), o[12:0], h);
            if (h) do_reset();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        step();
        test_reset();
        test_r();
        test_s_i();
        test_branch();
        test_halt();
        test_range();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/busca_controle.md
Name: busca_controle

Overview:
- Fetch stage and cycle sequencer of the multicycle RISC-V datapath.
- Holds the PC, a word-addressed instruction memory and the instruction register.
- Generates the 3-bit `estado` code that gates every downstream stage, including the decoder, which latches fields when estado==001.
- Uses `tipo` from the decoder and the branch result from execute to choose the next state and the next PC.

Parameters:
- MEM_DEPTH, 64, number of 32-bit instruction words; power of two, at least 2.
- ADDR_W, 6, log2(MEM_DEPTH); word-index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- prog_we  input  1  instruction-memory write enable (program load)
- prog_addr  input  ADDR_W  word index for program load
- prog_data  input  32  word written on prog_we
- tipo  input  3  format code from decoder: 000 I, 010 S, 011 R, 110 SB; valid from estado 010 onward
- desvio  input  1  branch-taken flag from execute; sampled only in EXECUTA for tipo 110
- desvio_offset  input  13  signed byte offset for the branch target, relative to the branch's own PC
- instrucao  output  32  instruction register, feeds the decoder
- pc  output  32  address of the instruction currently in flight
- estado  output  3  current cycle state
- parada  output  1  high while halted

Behaviour:
- Reset (async, immediate):
  - pc=0, instrucao=0, estado=000, parada=0.
  - Memory contents are not cleared.
- States (encoding = estado):
  - 000 BUSCA: always goes to 001, except in the halt cases below.
  - 001 DECODIFICA: always goes to 010.
  - 010 EXECUTA:
    - tipo 011 -> 100.
    - tipo 000 -> 011.
    - tipo 010 -> 011.
    - tipo 110 -> 000.
    - Any other tipo -> 111.
  - 011 MEMORIA:
    - tipo 000 -> 100.
    - tipo 010 -> 000.
  - 100 ESCRITA: always goes to 000.
  - 111 PARADA: absorbing until reset; parada=1.
  - Unused codes 101 and 110 go to 111.
- Fetch, on the posedge with estado==000:
  - instrucao <= mem[pc[ADDR_W+1:2]].
  - If that word is 32'h0, go to 111 instead of 001, and leave instrucao unchanged.
  - If pc[31:ADDR_W+2] != 0 (out of range), go to 111 without reading.
  - pc[1:0] is always 00; no misalignment check.
- Latency per instruction (clock edges):
  - R: 4 (000,001,010,100).
  - I: 5 (000,001,010,011,100).
  - S: 4 (000,001,010,011).
  - SB: 3 (000,001,010).
- PC update happens only on the edge that returns estado to 000:
  - Default: pc <= pc+4, with 32-bit wrap.
  - On the 010->000 edge with tipo==110 and desvio==1: pc <= pc + sign_extend32(desvio_offset).
  - desvio is ignored in every other state or tipo.
  - No PC change on the edge into 111.
- Program memory write:
  - On a posedge with prog_we=1: mem[prog_addr] <= prog_data, in any state, including PARADA and reset-inactive cycles.
  - Write and fetch of the same word on the same edge: the fetch returns the old word.
- Reset mid-instruction: all registers return to their reset values at once; the next instruction starts fetching from address 0.
- Outputs are registered and change only on posedge clk or reset.

Test Plan:
- Reset check:
  - Assert reset mid-EXECUTA with pc=0x8 and instrucao=0x00208133 -> estado=000, pc=0, instrucao=0 immediately, without waiting for a clock edge.
  - After release, word 0 is fetched on the next edge.
- R sequence:
  - Load mem[0]=0x00208133 (add). Drive tipo=011 from estado 010.
  - Expect estado 000,001,010,100,000 on successive edges.
  - Expect instrucao=0x00208133 after edge 1 and pc=4 after edge 4.
- S and I paths:
  - mem[0] store with tipo=010 -> states 000,001,010,011,000 and pc=4.
  - mem[1] load with tipo=000 -> states 000,001,010,011,100,000 and pc=8.
- Branch:
  - Word at pc=0x10, tipo=110, desvio=1, desvio_offset=-8 (13'h1FF8) -> pc=0x08 after 3 edges.
  - Same case with desvio=0 -> pc=0x14.
  - desvio=1 asserted while tipo=011 -> no effect, pc+4.
- Halt:
  - mem[2]=0 -> on the fetch edge at pc=8, estado=111, parada=1, instrucao keeps the previous word.
  - pc stays 8 for 10 further edges; reset clears parada.
- Range and write collision:
  - Branch to pc=0x100 with MEM_DEPTH=64 -> next fetch edge goes to 111.
  - prog_we to the word being fetched on the same edge -> instrucao gets the old value; a later fetch gets the new value.
